// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder: fills an 8-byte look-ahead, scans a 30-entry history
// one distance per cycle, then emits a (pos, len, char) triple under valid/ack.
// Stream ends after the '$' triple; finish stays high until reset.
module lz77_encoder #(
  parameter int SB_DEPTH = 30,
  parameter int LA_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ack,
  output logic [4:0] code_pos,
  output logic [4:0] code_len,
  output logic [7:0] chardata,
  output logic       finish
);

  localparam logic [7:0] EOS = 8'h24;
  localparam int HIW = $clog2(SB_DEPTH);
  localparam int LIW = $clog2(LA_DEPTH);
  localparam int HCW = $clog2(SB_DEPTH + 1);
  localparam int LCW = $clog2(LA_DEPTH + 1);

  typedef enum logic [1:0] {S_FILL, S_SEARCH, S_EMIT, S_DONE} state_t;

  state_t                       r_state;
  logic [SB_DEPTH-1:0][7:0]     r_hist;
  logic [LA_DEPTH-1:0][7:0]     r_la;
  logic [HCW-1:0]               r_hist_cnt;
  logic [LCW-1:0]               r_la_cnt;
  logic                         r_eos;
  logic [4:0]                   r_pos;
  logic [4:0]                   r_best_pos;
  logic [4:0]                   r_best_len;
  logic                         r_out_valid;
  logic [4:0]                   r_code_pos;
  logic [4:0]                   r_code_len;
  logic [7:0]                   r_chardata;
  logic                         r_finish;

  logic [4:0]                   w_run;
  logic                         w_better;
  logic [4:0]                   w_nbest_len;
  logic [4:0]                   w_nbest_pos;
  logic [SB_DEPTH-1:0][7:0]     w_hist_sh;
  logic [LA_DEPTH-1:0][7:0]     w_la_sh;
  logic [HCW-1:0]               w_hist_cnt_nx;
  logic                         w_accept;
  logic                         w_last_pos;

  // Accept bytes only while filling, before '$', with room left; gated by reset.
  assign in_ready = reset && (r_state == S_FILL) && !r_eos && (r_la_cnt < LCW'(LA_DEPTH));
  assign w_accept = in_valid && in_ready;
  assign w_last_pos = (r_pos == 5'(SB_DEPTH - 1));

  assign out_valid = r_out_valid;
  assign code_pos  = r_code_pos;
  assign code_len  = r_code_len;
  assign chardata  = r_chardata;
  assign finish    = r_finish;

  // Match run length at distance r_pos+1; sources before the look-ahead come
  // from history, later ones from the look-ahead itself (overlapping copies).
  always_comb begin
    int d;
    int cap;
    int run;
    logic go;
    logic [7:0] src;
    d   = int'(r_pos) + 1;
    cap = int'(r_la_cnt) - 1;
    run = 0;
    go  = 1'b1;
    src = '0;
    for (int k = 0; k < LA_DEPTH; k++) begin
      if (k >= d) src = r_la[LIW'(k - d)];
      else        src = r_hist[HIW'(d - k - 1)];
      if (go && (k < cap) && (r_la[LIW'(k)] == src)) run = run + 1;
      else go = 1'b0;
    end
    w_run = 5'(run);
  end

  // Strictly-greater update keeps the smallest position on ties.
  always_comb begin
    w_better    = (r_pos < 5'(r_hist_cnt)) && (w_run > r_best_len);
    w_nbest_len = w_better ? w_run : r_best_len;
    w_nbest_pos = w_better ? r_pos : r_best_pos;
  end

  // Next history/look-ahead after consuming best_len+1 look-ahead bytes.
  always_comb begin
    int l;
    int hsum;
    l = int'(r_best_len);
    for (int j = 0; j < SB_DEPTH; j++) begin
      if (j <= l) w_hist_sh[HIW'(j)] = r_la[LIW'(l - j)];
      else        w_hist_sh[HIW'(j)] = r_hist[HIW'(j - l - 1)];
    end
    for (int k = 0; k < LA_DEPTH; k++) begin
      if (k + l + 1 < LA_DEPTH) w_la_sh[LIW'(k)] = r_la[LIW'(k + l + 1)];
      else                      w_la_sh[LIW'(k)] = '0;
    end
    hsum = int'(r_hist_cnt) + l + 1;
    w_hist_cnt_nx = (hsum > SB_DEPTH) ? HCW'(SB_DEPTH) : HCW'(hsum);
  end

  // Main FSM: fill, search, emit, done; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_FILL;
      r_hist      <= '0;
      r_la        <= '0;
      r_hist_cnt  <= '0;
      r_la_cnt    <= '0;
      r_eos       <= 1'b0;
      r_pos       <= '0;
      r_best_pos  <= '0;
      r_best_len  <= '0;
      r_out_valid <= 1'b0;
      r_code_pos  <= '0;
      r_code_len  <= '0;
      r_chardata  <= '0;
      r_finish    <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (r_eos || (r_la_cnt == LCW'(LA_DEPTH))) begin
            r_state    <= S_SEARCH;
            r_pos      <= '0;
            r_best_pos <= '0;
            r_best_len <= '0;
          end else if (w_accept) begin
            r_la[r_la_cnt[LIW-1:0]] <= in_data;
            r_la_cnt <= r_la_cnt + 1'b1;
            if (in_data == EOS) r_eos <= 1'b1;
          end
        end
        S_SEARCH: begin
          r_best_pos <= w_nbest_pos;
          r_best_len <= w_nbest_len;
          if (w_last_pos) begin
            r_state     <= S_EMIT;
            r_out_valid <= 1'b1;
            r_code_pos  <= w_nbest_pos;
            r_code_len  <= w_nbest_len;
            r_chardata  <= r_la[w_nbest_len[LIW-1:0]];
          end else begin
            r_pos <= r_pos + 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ack) begin
            r_hist      <= w_hist_sh;
            r_la        <= w_la_sh;
            r_hist_cnt  <= w_hist_cnt_nx;
            r_la_cnt    <= r_la_cnt - LCW'(int'(r_best_len) + 1);
            r_out_valid <= 1'b0;
            if (r_chardata == EOS) begin
              r_state  <= S_DONE;
              r_finish <= 1'b1;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        default: begin
          r_state <= S_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lz77_encoder.sv
// Scoreboard bench for lz77_encoder: a flat-string LZ77 model pushes expected
// triples; a monitor pops and compares on every transfer.
module tb_lz77_encoder;

  typedef logic [7:0] byte_q [$];
  localparam logic [7:0] EOS = 8'h24;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ack;
  logic [4:0] code_pos;
  logic [4:0] code_len;
  logic [7:0] chardata;
  logic       finish;

  int checks = 0;
  int errors = 0;
  int ack_mode = 0;
  int la_occ = 0;
  logic [17:0] exp_q [$];

  lz77_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ack(out_ack),
    .code_pos(code_pos), .code_len(code_len), .chardata(chardata),
    .finish(finish)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic byte_q str2q(input string s);
    byte_q q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: greedy LZ77 over the flat string. History = last min(30,p)
  // bytes; look-ahead holds min(8, remaining) bytes so the match is capped at
  // min(7, remaining-1). Distance d maps to code_pos d-1.
  function automatic void model(input byte_q s);
    int p, rem, cap, bl, bp, nd, l;
    p = 0;
    while (p < s.size()) begin
      rem = s.size() - p;
      cap = (rem - 1 > 7) ? 7 : rem - 1;
      nd  = (p < 30) ? p : 30;
      bl = 0;
      bp = 0;
      for (int d = 1; d <= nd; d++) begin
        l = 0;
        while (l < cap && s[p + l] == s[p + l - d]) l++;
        if (l > bl) begin
          bl = l;
          bp = d - 1;
        end
      end
      exp_q.push_back({5'(bp), 5'(bl), s[p + bl]});
      p = p + bl + 1;
    end
  endfunction

  // Consumer ack: 0 = tied high, 1 = hold off 5 valid cycles, 2 = random.
  initial begin
    int wc;
    wc = 0;
    out_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) wc++;
      else wc = 0;
      case (ack_mode)
        0:       out_ack = 1'b1;
        1:       out_ack = (wc > 5);
        default: out_ack = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // Monitor: compares each transferred triple, output stability while stalled,
  // no input acceptance during EMIT, and the finish/DONE behaviour.
  initial begin
    logic held;
    logic pend_fin;
    logic [17:0] prev;
    logic [17:0] e;
    held = 1'b0;
    pend_fin = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 1'b0;
        pend_fin = 1'b0;
      end else begin
        if (pend_fin) begin
          chk("finish_after_eos", {31'd0, finish}, 32'd1);
          chk("valid_drop_after_eos", {31'd0, out_valid}, 32'd0);
          pend_fin = 1'b0;
        end else if (finish) begin
          chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        end
        if (out_valid) begin
          chk("in_ready_during_emit", {31'd0, in_ready}, 32'd0);
          if (held) chk("hold_stable", {14'd0, code_pos, code_len, chardata}, {14'd0, prev});
          if (out_ack) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_triple", {14'd0, code_pos, code_len, chardata}, 32'hFFFFFFFF);
            end else begin
              e = exp_q.pop_front();
              chk("triple", {14'd0, code_pos, code_len, chardata}, {14'd0, e});
            end
            la_occ = la_occ - (int'(code_len) + 1);
            if (chardata == EOS) pend_fin = 1'b1;
            held = 1'b0;
          end else begin
            held = 1'b1;
            prev = {code_pos, code_len, chardata};
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_code"},      {14'd0, code_pos, code_len, chardata}, 32'd0);
    chk({tag, "_finish"},    {31'd0, finish}, 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b0;
    exp_q.delete();
    la_occ = 0;
    #1;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Offer bytes; optionally keep offering junk after '$' until finish.
  task automatic send(input byte_q s, input bit gaps, input bit to_end);
    int w;
    int extra;
    for (int i = 0; i < s.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = s[i];
      w = 0;
      forever begin
        @(negedge clk);
        if (la_occ >= 8) chk("in_ready_full_la", {31'd0, in_ready}, 32'd0);
        if (in_ready) begin
          @(posedge clk);
          #1;
          la_occ++;
          break;
        end
        @(posedge clk);
        #1;
        w++;
        if (w > 2000) begin
          chk("byte_accept_timeout", 32'd0, 32'd1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    if (!to_end) return;
    in_valid = 1'b1;
    in_data  = 8'h7a;
    extra = 0;
    w = 0;
    while (!finish && w < 4000) begin
      @(negedge clk);
      if (in_ready) extra++;
      @(posedge clk);
      #1;
      w++;
    end
    in_valid = 1'b0;
    chk("finish_seen", {31'd0, finish}, 32'd1);
    chk("bytes_after_eos", 32'(extra), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_case(input byte_q s, input int mode, input bit gaps);
    do_reset();
    ack_mode = mode;
    model(s);
    send(s, gaps, 1'b1);
  endtask

  initial begin
    byte_q s;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Literal-only, overlapping run, distant match, look-ahead cap.
    run_case(str2q("ab$"), 0, 1'b0);
    run_case(str2q("aaaaa$"), 0, 1'b0);
    run_case(str2q("abcabc$"), 0, 1'b0);
    run_case(str2q("xxxxxxxxxxxx$"), 0, 1'b0);

    // Backpressure on every triple.
    run_case(str2q("abcabc$"), 1, 1'b0);

    // Reset in the middle of the first search, then replay.
    do_reset();
    ack_mode = 0;
    send(str2q("abcabc$"), 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_vals("mid_search_reset");
    run_case(str2q("abcabc$"), 0, 1'b0);

    // Randomized streams from a small alphabet so matches are common.
    for (int n = 0; n < 16; n++) begin
      int len;
      s.delete();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) s.push_back(8'h30 + 8'($urandom_range(0, 9)));
        else s.push_back(8'h61 + 8'($urandom_range(0, 2)));
      end
      s.push_back(EOS);
      run_case(s, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
